rot13_link_host: RTL

Host-side initiator for the 4-bit nibble-load / ROT13-transform link. It accepts bytes on a valid/ready stream and drives the low nibble, the high nibble and the transform command onto the link. It checks the device acknowledge patterns, captures the transformed byte and returns it on an output stream. The result is also checked against an internal ROT13 model. It sits in the test/harness side of the design, facing the 8-in/8-out device pins.

---
 rtl/rot13_link_pkg.sv | 34 +++
 rtl/rot13_link_host_if.sv | 30 +++
 rtl/rot13_link_phase_timer.sv | 44 ++++
 rtl/rot13_link_host.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rot13_link_pkg.sv
// Shared constants, state encoding and the ROT13 reference used to check device results.
package rot13_link_pkg;

    localparam logic [1:0] CTL_LOW   = 2'b00;
    localparam logic [1:0] CTL_HIGH  = 2'b01;
    localparam logic [1:0] CTL_XFORM = 2'b10;
    localparam logic [7:0] ACK_LOW   = 8'h0F;
    localparam logic [7:0] ACK_HIGH  = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StPhLo,
        StPhHi,
        StPhXf,
        StDone,
        StAbort
    } state_e;

    // Letters rotate by 13; other 7-bit codes pass through; the upper half maps to zero.
    function automatic logic [7:0] rot13_ref(input logic [7:0] b);
        logic [7:0] r;
        if (b[7]) begin
            r = 8'h00;
        end else if ((b >= 8'h41 && b <= 8'h4D) || (b >= 8'h61 && b <= 8'h6D)) begin
            r = b + 8'd13;
        end else if ((b >= 8'h4E && b <= 8'h5A) || (b >= 8'h6E && b <= 8'h7A)) begin
            r = b - 8'd13;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/rot13_link_host_if.sv
// Byte streams plus device-link pins of the ROT13 link host; master is the host side.
interface rot13_link_host_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_mismatch;
    logic [1:0] link_ctl;
    logic [3:0] link_data;
    logic [7:0] link_rsp;
    logic       link_rst;
    logic       err_ack;
    logic       busy;

    modport master (
        input  in_data, in_valid, out_ready, link_rsp,
        output in_ready, out_data, out_valid, out_mismatch, link_ctl, link_data, link_rst,
               err_ack, busy
    );

    modport slave (
        output in_data, in_valid, out_ready, link_rsp,
        input  in_ready, out_data, out_valid, out_mismatch, link_ctl, link_data, link_rst,
               err_ack, busy
    );

endinterface

// File: rtl/rot13_link_phase_timer.sv
// Per-phase wait counter and retry counter for the link host sequencer.
module rot13_link_phase_timer #(
    parameter int unsigned RSP_DELAY = 1,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic retry_clr_i,
    input  logic retry_inc_i,
    output logic sample_now_o,
    output logic retry_exhausted_o
);

    localparam int unsigned WaitW = $clog2(RSP_DELAY + 1);

    logic [WaitW-1:0] wait_q, wait_d;
    logic [2:0]       retry_q, retry_d;

    assign sample_now_o      = active_i && (wait_q == WaitW'(RSP_DELAY));
    assign retry_exhausted_o = (retry_q >= 3'(MAX_RETRY));

    // Clearing at the sample edge restarts the count for whichever phase comes next.
    always_comb begin
        wait_d  = (active_i && !sample_now_o) ? wait_q + WaitW'(1) : '0;
        retry_d = retry_q;
        if (retry_clr_i) begin
            retry_d = '0;
        end else if (retry_inc_i) begin
            retry_d = retry_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q  <= '0;
            retry_q <= '0;
        end else begin
            wait_q  <= wait_d;
            retry_q <= retry_d;
        end
    end

endmodule

// File: rtl/rot13_link_host.sv
// Host initiator: loads a byte as two nibbles, requests the transform and returns the result.
module rot13_link_host
    import rot13_link_pkg::*;
#(
    parameter int unsigned RSP_DELAY = 1,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    rot13_link_host_if.master         bus
);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_mismatch_q, out_mismatch_d;
    logic [1:0] link_ctl_q, link_ctl_d;
    logic [3:0] link_data_q, link_data_d;
    logic       link_rst_q, link_rst_d;
    logic       err_ack_q, err_ack_d;

    logic in_phase, sample_now, retry_exhausted, retry_clr, retry_inc;

    assign in_phase = (state_q == StPhLo) || (state_q == StPhHi) || (state_q == StPhXf);

    rot13_link_phase_timer #(
        .RSP_DELAY (RSP_DELAY),
        .MAX_RETRY (MAX_RETRY)
    ) u_timer (
        .clk               (clk),
        .reset             (reset),
        .active_i          (in_phase),
        .retry_clr_i       (retry_clr),
        .retry_inc_i       (retry_inc),
        .sample_now_o      (sample_now),
        .retry_exhausted_o (retry_exhausted)
    );

    always_comb begin
        state_d        = state_q;
        byte_d         = byte_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_mismatch_d = out_mismatch_q;
        link_ctl_d     = link_ctl_q;
        link_data_d    = link_data_q;
        link_rst_d     = 1'b0;
        err_ack_d      = err_ack_q;
        retry_clr      = 1'b0;
        retry_inc      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    byte_d      = bus.in_data;
                    state_d     = StPhLo;
                    retry_clr   = 1'b1;
                    link_ctl_d  = CTL_LOW;
                    link_data_d = bus.in_data[3:0];
                end
            end
            StPhLo, StPhHi: begin
                if (sample_now) begin
                    if (bus.link_rsp == ((state_q == StPhLo) ? ACK_LOW : ACK_HIGH)) begin
                        retry_clr = 1'b1;
                        if (state_q == StPhLo) begin
                            state_d     = StPhHi;
                            link_ctl_d  = CTL_HIGH;
                            link_data_d = byte_q[7:4];
                        end else begin
                            state_d     = StPhXf;
                            link_ctl_d  = CTL_XFORM;
                            link_data_d = '0;
                        end
                    end else if (!retry_exhausted) begin
                        // Stay put with the same drive; the timer restarts the phase.
                        retry_inc = 1'b1;
                    end else begin
                        state_d     = StAbort;
                        link_ctl_d  = CTL_XFORM;
                        link_data_d = '0;
                        link_rst_d  = 1'b1;
                        err_ack_d   = 1'b1;
                    end
                end
            end
            StPhXf: begin
                if (sample_now) begin
                    out_data_d     = bus.link_rsp;
                    out_mismatch_d = (bus.link_rsp != rot13_ref(byte_q));
                    out_valid_d    = 1'b1;
                    state_d        = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            byte_q         <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_mismatch_q <= 1'b0;
            link_ctl_q     <= CTL_XFORM;
            link_data_q    <= '0;
            link_rst_q     <= 1'b1;
            err_ack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_q         <= byte_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_mismatch_q <= out_mismatch_d;
            link_ctl_q     <= link_ctl_d;
            link_data_q    <= link_data_d;
            link_rst_q     <= link_rst_d;
            err_ack_q      <= err_ack_d;
        end
    end

    assign bus.in_ready     = (state_q == StIdle) && !reset;
    assign bus.busy         = (state_q != StIdle);
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_mismatch = out_mismatch_q;
    assign bus.link_ctl     = link_ctl_q;
    assign bus.link_data    = link_data_q;
    assign bus.link_rst     = link_rst_q;
    assign bus.err_ack      = err_ack_q;

endmodule
